// File: rtl/alu_wide_pkg.sv
// Shared definitions for the two-pass 16-bit ALU sequencer: op codes, sequencer
// states and flag bit positions within the {Z,N,H,C} nibble.
package alu_wide_pkg;

  typedef enum logic [1:0] {
    ADD_HL_RR  = 2'b00,
    ADD_SP_E   = 2'b01,
    LD_HL_SP_E = 2'b10,
    OP_RSVD    = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LO   = 2'b01,
    HI   = 2'b10,
    DONE = 2'b11
  } state_e;

  localparam int unsigned FLAG_Z = 3;
  localparam int unsigned FLAG_N = 2;
  localparam int unsigned FLAG_H = 1;
  localparam int unsigned FLAG_C = 0;

endpackage

// File: rtl/alu_wide_seq_if.sv
// Link between the wide sequencer and the 8-bit ALU it drives and reads back.
interface alu_wide_seq_if;
  logic       alu_en;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic       alu_cin;
  logic [7:0] alu_res;
  logic       alu_cout;
  logic       alu_hout;

  modport master (
    output alu_en, alu_a, alu_b, alu_cin,
    input  alu_res, alu_cout, alu_hout
  );

  modport slave (
    input  alu_en, alu_a, alu_b, alu_cin,
    output alu_res, alu_cout, alu_hout
  );
endinterface

// File: rtl/alu_wide_capture.sv
// Per-pass capture of the ALU sum, carry-out of bit 7 and carry-out of bit 3.
module alu_wide_capture (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [7:0] d_res,
  input  logic       d_cout,
  input  logic       d_hout,
  output logic [7:0] q_res,
  output logic       q_cout,
  output logic       q_hout
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_res  <= '0;
      q_cout <= 1'b0;
      q_hout <= 1'b0;
    end else if (load) begin
      q_res  <= d_res;
      q_cout <= d_cout;
      q_hout <= d_hout;
    end
  end

endmodule

// File: rtl/alu_wide_seq.sv
// Two-pass SM83 16-bit add sequencer (low byte, then high byte with carry).
// Define ALU_WIDE_SEQ_ABORT_EN to add the abort input.
module alu_wide_seq
  import alu_wide_pkg::*;
(
  input  logic           CLK,
  input  logic           nRESET,
  input  logic           start,
  input  logic [1:0]     op,
  input  logic [15:0]    opa,
  input  logic [15:0]    opb,
`ifdef ALU_WIDE_SEQ_ABORT_EN
  input  logic           abort,
`endif
  alu_wide_seq_if.master alu,
  output logic           busy,
  output logic           done,
  output logic [15:0]    result,
  output logic           dest_sp,
  output logic [3:0]     flags,
  output logic [3:0]     flags_we
);

  state_e      state_q, state_d;
  op_e         op_in, op_q;
  logic [15:0] opa_q;
  logic [7:0]  opb_lo_q, opb_hi_q;
  logic [15:0] result_q;
  logic        accept, abort_hit;
  logic [7:0]  res_lo, res_hi;
  logic        c_lo, h_lo, c_hi, h_hi;

  assign op_in  = op_e'(op);
  assign accept = (state_q == IDLE) && start && (op_in != OP_RSVD);

`ifdef ALU_WIDE_SEQ_ABORT_EN
  assign abort_hit = abort && ((state_q == LO) || (state_q == HI));
`else
  assign abort_hit = 1'b0;
`endif

  alu_wide_capture u_cap_lo (
    .clk    (CLK),
    .rst_n  (nRESET),
    .load   (state_q == LO),
    .d_res  (alu.alu_res),
    .d_cout (alu.alu_cout),
    .d_hout (alu.alu_hout),
    .q_res  (res_lo),
    .q_cout (c_lo),
    .q_hout (h_lo)
  );

  alu_wide_capture u_cap_hi (
    .clk    (CLK),
    .rst_n  (nRESET),
    .load   (state_q == HI),
    .d_res  (alu.alu_res),
    .d_cout (alu.alu_cout),
    .d_hout (alu.alu_hout),
    .q_res  (res_hi),
    .q_cout (c_hi),
    .q_hout (h_hi)
  );

  always_ff @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      state_q  <= IDLE;
      op_q     <= ADD_HL_RR;
      opa_q    <= '0;
      opb_lo_q <= '0;
      opb_hi_q <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q     <= op_in;
        opa_q    <= opa;
        opb_lo_q <= opb[7:0];
        opb_hi_q <= (op_in == ADD_HL_RR) ? opb[15:8] : {8{opb[7]}};
      end
      // Captures are overwritten by the next op's passes, so the visible
      // result is frozen here; an aborted op never reaches DONE.
      if (state_q == DONE)
        result_q <= {res_hi, res_lo};
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = LO;
      LO:      state_d = abort_hit ? IDLE : HI;
      HI:      state_d = abort_hit ? IDLE : DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    alu.alu_en  = 1'b0;
    alu.alu_a   = '0;
    alu.alu_b   = '0;
    alu.alu_cin = 1'b0;
    done        = 1'b0;
    result      = result_q;
    dest_sp     = busy && (op_q == ADD_SP_E);
    flags       = '0;
    flags_we    = '0;
    unique case (state_q)
      LO: begin
        alu.alu_en = 1'b1;
        alu.alu_a  = opa_q[7:0];
        alu.alu_b  = opb_lo_q;
      end
      HI: begin
        alu.alu_en  = 1'b1;
        alu.alu_a   = opa_q[15:8];
        alu.alu_b   = opb_hi_q;
        alu.alu_cin = c_lo;
      end
      DONE: begin
        done   = 1'b1;
        result = {res_hi, res_lo};
        if (op_q == ADD_HL_RR) begin
          flags_we       = 4'b0111;
          flags[FLAG_H]  = h_hi;
          flags[FLAG_C]  = c_hi;
        end else begin
          flags_we       = 4'b1111;
          flags[FLAG_H]  = h_lo;
          flags[FLAG_C]  = c_lo;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_wide_seq.sv
// Randomized bench for alu_wide_seq: 16-bit arithmetic reference model,
// per-cycle compare process and a few literal expectations.
module tb_alu_wide_seq;

  logic        CLK = 1'b0;
  logic        nRESET = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] opa = '0;
  logic [15:0] opb = '0;
`ifdef ALU_WIDE_SEQ_ABORT_EN
  logic        abort = 1'b0;
`endif
  logic        busy, done, dest_sp;
  logic [15:0] result;
  logic [3:0]  flags, flags_we;
  logic        ab_in;

  int vectors = 0;
  int miscompares = 0;

  alu_wide_seq_if aif ();

  alu_wide_seq dut (
    .CLK      (CLK),
    .nRESET   (nRESET),
    .start    (start),
    .op       (op),
    .opa      (opa),
    .opb      (opb),
`ifdef ALU_WIDE_SEQ_ABORT_EN
    .abort    (abort),
`endif
    .alu      (aif),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .dest_sp  (dest_sp),
    .flags    (flags),
    .flags_we (flags_we)
  );

`ifdef ALU_WIDE_SEQ_ABORT_EN
  assign ab_in = abort;
`else
  assign ab_in = 1'b0;
`endif

  always #5 CLK = ~CLK;

  // Bench-side 8-bit ALU: plain adder with bit-3 half carry.
  logic [8:0] alu_sum;
  logic [4:0] alu_nib;
  assign alu_sum = {1'b0, aif.alu_a} + {1'b0, aif.alu_b} + {8'b0, aif.alu_cin};
  assign alu_nib = {1'b0, aif.alu_a[3:0]} + {1'b0, aif.alu_b[3:0]} + {4'b0, aif.alu_cin};
  assign aif.alu_res  = alu_sum[7:0];
  assign aif.alu_cout = alu_sum[8];
  assign aif.alu_hout = alu_nib[4];

  typedef struct {
    logic [15:0] a;
    logic [15:0] b16;
    logic [15:0] res;
    logic        c_lo;
    logic [3:0]  flags;
    logic [3:0]  we;
    logic        dest;
    logic        pin_en;
    logic [15:0] pin_res;
    logic [3:0]  pin_flags;
    logic [3:0]  pin_we;
    logic        pin_dest;
  } txn_t;

  function automatic txn_t model(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b);
    txn_t t;
    logic [15:0] b16;
    logic [16:0] sum;
    logic [12:0] h12;
    logic [8:0]  lo9;
    logic [4:0]  h4;
    b16 = (o == 2'b00) ? b : {{8{b[7]}}, b[7:0]};
    sum = {1'b0, a} + {1'b0, b16};
    h12 = {1'b0, a[11:0]} + {1'b0, b16[11:0]};
    lo9 = {1'b0, a[7:0]} + {1'b0, b16[7:0]};
    h4  = {1'b0, a[3:0]} + {1'b0, b16[3:0]};
    t = '{default: '0};
    t.a    = a;
    t.b16  = b16;
    t.res  = sum[15:0];
    t.c_lo = lo9[8];
    if (o == 2'b00) begin
      t.flags = {2'b00, h12[12], sum[16]};
      t.we    = 4'b0111;
      t.dest  = 1'b0;
    end else begin
      t.flags = {2'b00, h4[4], lo9[8]};
      t.we    = 4'b1111;
      t.dest  = (o == 2'b01);
    end
    return t;
  endfunction

  logic        drv_pin_en = 1'b0;
  logic [15:0] drv_pin_res = '0;
  logic [3:0]  drv_pin_flags = '0;
  logic [3:0]  drv_pin_we = '0;
  logic        drv_pin_dest = 1'b0;

  // Reference: phase counts cycles since acceptance (0 = no op in flight).
  int          phase = 0;
  txn_t        cur;
  logic [15:0] hold = '0;

  always @(posedge CLK or negedge nRESET) begin
    if (!nRESET) begin
      phase = 0;
      hold  = '0;
    end else begin
      case (phase)
        0: if (start && op != 2'b11) begin
             cur           = model(op, opa, opb);
             cur.pin_en    = drv_pin_en;
             cur.pin_res   = drv_pin_res;
             cur.pin_flags = drv_pin_flags;
             cur.pin_we    = drv_pin_we;
             cur.pin_dest  = drv_pin_dest;
             phase = 1;
           end
        1: phase = ab_in ? 0 : 2;
        2: phase = ab_in ? 0 : 3;
        default: begin
          hold  = cur.res;
          phase = 0;
        end
      endcase
    end
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge CLK) begin
    if (!nRESET) begin
      chk("rst_busy", 16'(busy), 16'h0);
      chk("rst_alu_en", 16'(aif.alu_en), 16'h0);
      chk("rst_alu_a", 16'(aif.alu_a), 16'h0);
      chk("rst_alu_b", 16'(aif.alu_b), 16'h0);
      chk("rst_alu_cin", 16'(aif.alu_cin), 16'h0);
      chk("rst_done", 16'(done), 16'h0);
      chk("rst_result", result, 16'h0);
      chk("rst_dest_sp", 16'(dest_sp), 16'h0);
      chk("rst_flags", 16'(flags), 16'h0);
      chk("rst_flags_we", 16'(flags_we), 16'h0);
    end else begin
      chk("busy", 16'(busy), 16'(phase != 0));
      chk("alu_en", 16'(aif.alu_en), 16'(phase == 1 || phase == 2));
      chk("alu_a", 16'(aif.alu_a),
          (phase == 1) ? 16'(cur.a[7:0]) : (phase == 2) ? 16'(cur.a[15:8]) : 16'h0);
      chk("alu_b", 16'(aif.alu_b),
          (phase == 1) ? 16'(cur.b16[7:0]) : (phase == 2) ? 16'(cur.b16[15:8]) : 16'h0);
      chk("alu_cin", 16'(aif.alu_cin), (phase == 2) ? 16'(cur.c_lo) : 16'h0);
      chk("done", 16'(done), 16'(phase == 3));
      if (phase == 3) begin
        chk("result", result, cur.res);
        chk("flags", 16'(flags), 16'(cur.flags));
        chk("flags_we", 16'(flags_we), 16'(cur.we));
        chk("dest_sp", 16'(dest_sp), 16'(cur.dest));
        if (cur.pin_en) begin
          chk("pin_result", result, cur.pin_res);
          chk("pin_flags", 16'(flags), 16'(cur.pin_flags));
          chk("pin_flags_we", 16'(flags_we), 16'(cur.pin_we));
          chk("pin_dest_sp", 16'(dest_sp), 16'(cur.pin_dest));
        end
      end else begin
        chk("result_hold", result, hold);
        chk("flags_idle", 16'(flags), 16'h0);
        chk("flags_we_idle", 16'(flags_we), 16'h0);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_pin(input logic [15:0] r, input logic [3:0] f, input logic [3:0] w, input logic d);
    drv_pin_en    = 1'b1;
    drv_pin_res   = r;
    drv_pin_flags = f;
    drv_pin_we    = w;
    drv_pin_dest  = d;
  endtask

  task automatic run_pinned(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                            input logic [15:0] r, input logic [3:0] f, input logic [3:0] w,
                            input logic d);
    set_pin(r, f, w, d);
    op = o; opa = a; opb = b; start = 1'b1;
    tick();
    start = 1'b0;
    drv_pin_en = 1'b0;
    opa = 16'($urandom);
    opb = 16'($urandom);
    repeat (4) tick();
  endtask

  initial begin
    nRESET = 1'b0;
    repeat (3) tick();
    nRESET = 1'b1;
    tick();

    run_pinned(2'b00, 16'hFFFF, 16'h0001, 16'h0000, 4'b0011, 4'b0111, 1'b0);
    run_pinned(2'b00, 16'h0FFF, 16'h0001, 16'h1000, 4'b0010, 4'b0111, 1'b0);
    run_pinned(2'b00, 16'h8000, 16'h8000, 16'h0000, 4'b0001, 4'b0111, 1'b0);
    run_pinned(2'b01, 16'hFFF8, 16'h0008, 16'h0000, 4'b0011, 4'b1111, 1'b1);
    run_pinned(2'b10, 16'h0000, 16'h00FF, 16'hFFFF, 4'b0000, 4'b1111, 1'b0);

    // Start held through LO/HI/DONE with changing operands, then reserved op.
    set_pin(16'h2345, 4'b0000, 4'b0111, 1'b0);
    op = 2'b00; opa = 16'h1234; opb = 16'h1111; start = 1'b1;
    tick();
    drv_pin_en = 1'b0;
    repeat (3) begin
      op = 2'($urandom); opa = 16'($urandom); opb = 16'($urandom);
      tick();
    end
    op = 2'b11;
    repeat (2) tick();
    start = 1'b0;
    tick();

    // Reset in the middle of HI.
    op = 2'b00; opa = 16'h00F0; opb = 16'h0010; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2 nRESET = 1'b0;
    tick();
    tick();
    nRESET = 1'b1;
    tick();
    run_pinned(2'b01, 16'h1000, 16'h0080, 16'h0F80, 4'b0000, 4'b1111, 1'b1);

`ifdef ALU_WIDE_SEQ_ABORT_EN
    op = 2'b00; opa = 16'h0100; opb = 16'h0200; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    repeat (2) tick();
    run_pinned(2'b00, 16'h00FF, 16'h0001, 16'h0100, 4'b0000, 4'b0111, 1'b0);
`endif

    for (int i = 0; i < 1500; i++) begin
      start = ($urandom_range(0, 2) == 0);
      op    = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       opa = 16'hFFFF;
        1:       opa = 16'h0000;
        default: opa = 16'($urandom);
      endcase
      opb = 16'($urandom);
`ifdef ALU_WIDE_SEQ_ABORT_EN
      abort = ($urandom_range(0, 9) == 0);
`endif
      tick();
    end
    start = 1'b0;
`ifdef ALU_WIDE_SEQ_ABORT_EN
    abort = 1'b0;
`endif
    repeat (6) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
